mem_responder: RTL and testbench

//  Word-addressed memory responder: the target end of the CPU fetch/load/store bus.

---
 rtl/mem_responder.sv | 114 +++++++++++
 tb/tb_mem_responder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Word-addressed memory responder: one request at a time, programmable wait
// states, then a registered read-data / write-ack / error response.
module mem_responder #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int IdxW = $clog2(DEPTH);
  localparam logic [3:0] WaitLast = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic [IdxW-1:0]   idx_q;
  logic              write_q;
  logic              err_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              accept;
  logic              inRange;
  logic [IdxW-1:0]   idx_d;
  logic [DATA_W-1:0] rdata_d;
  logic              unused_addr;

  assign idx_d       = req_addr[IdxW+1:2];
  assign inRange     = (req_addr[ADDR_W-1:IdxW+2] == '0);
  assign accept      = (state_q == IDLE) && req_ready_q && req_valid;
  assign rdata_d     = (write_q || err_q) ? '0 : mem_q[idx_q];
  assign unused_addr = ^req_addr[1:0];

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // Storage has no reset so its contents survive rst_n.
  always_ff @(posedge clk) begin
    if (accept && req_write && inRange) begin
      mem_q[idx_d] <= req_wdata;
    end
  end

  // WAIT always lasts WAIT_STATES+1 cycles, so the response register is loaded
  // on edge accept+1+WAIT_STATES even when no wait states are configured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      write_q     <= 1'b0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (accept) begin
            idx_q       <= idx_d;
            write_q     <= req_write;
            err_q       <= !inRange;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == WaitLast) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rdata_d;
            rsp_err_q   <= err_q;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: one instance with one wait state and a
// second with none to check back-to-back turnaround.
module tb_mem_responder;

  localparam int WS = 1;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          acceptEdge;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic        req_valid0, req_ready0, req_write0, rsp_valid0, rsp_ready0, rsp_err0;
  logic [31:0] req_addr0, req_wdata0, rsp_rdata0;

  exp_t        sb[$];
  exp_t        sb0[$];
  logic [31:0] model [256];
  logic [31:0] model0 [256];
  bit          written [16];
  int          checks = 0;
  int          failures = 0;
  int          edgeCount = 0;
  int          lastRsp0 = -1;
  int          count0 = 0;
  logic        prevValid = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) edgeCount <= edgeCount + 1;

  mem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  mem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_write(req_write0),
    .req_addr(req_addr0), .req_wdata(req_wdata0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
    end
  endtask

  // Response monitor for the main instance: latency on rise, contents on handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prevValid = 1'b0;
    end else begin
      if (rsp_valid && !prevValid) begin
        if (sb.size() == 0) checkOutput("unexpectedRsp", 32'(rsp_valid), 32'd0);
        else checkOutput("latency", 32'(edgeCount - sb[0].acceptEdge), 32'(1 + WS));
      end
      if (rsp_valid && rsp_ready && sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("rspErr", 32'(rsp_err), 32'(e.err));
        checkOutput("rspData", rsp_rdata, e.data);
      end
      prevValid = rsp_valid;
    end
  end

  // Monitor for the zero-wait instance; rsp_ready0 is tied high so each
  // response is valid for exactly one cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rsp_valid0) begin
      if (sb0.size() == 0) begin
        checkOutput("unexpectedRsp0", 32'(rsp_valid0), 32'd0);
      end else begin
        e = sb0.pop_front();
        checkOutput("latency0", 32'(edgeCount - e.acceptEdge), 32'd1);
        checkOutput("rspErr0", 32'(rsp_err0), 32'(e.err));
        checkOutput("rspData0", rsp_rdata0, e.data);
      end
      if (lastRsp0 >= 0) checkOutput("spacing0", 32'(edgeCount - lastRsp0), 32'd3);
      lastRsp0 = edgeCount;
      count0++;
    end
  end

  task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d,
                               input int stall, input bit keepValid);
    exp_t        e;
    logic [29:0] idx;
    int          n;
    idx   = a[31:2];
    e.err = (idx >= 30'd256);
    if (w) begin
      if (!e.err) model[idx[7:0]] = d;
      e.data = 32'd0;
    end else begin
      e.data = e.err ? 32'd0 : model[idx[7:0]];
    end
    rsp_ready = (stall == 0);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      checkOutput("acceptTimeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    e.acceptEdge = edgeCount;
    sb.push_back(e);
    if (!keepValid) req_valid = 1'b0;
    if (stall > 0) begin
      n = 0;
      while (!rsp_valid && n < 40) begin
        @(posedge clk); #1;
        n++;
      end
      checkOutput("stallValidSeen", 32'(rsp_valid), 32'd1);
      for (int i = 0; i < stall; i++) begin
        @(posedge clk); #1;
        checkOutput("stallValid", 32'(rsp_valid), 32'd1);
        checkOutput("stallData", rsp_rdata, e.data);
        checkOutput("stallErr", 32'(rsp_err), 32'(e.err));
        checkOutput("stallNoAccept", 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      req_valid = 1'b0;
    end
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      checkOutput("rspTimeout", 32'd0, 32'd1);
      sb.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] addrs0 [6];
    logic [31:0] datas0 [6];
    exp_t        e;
    int          n;
    int          idx;
    logic [31:0] d;

    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    req_valid0 = 1'b0; req_write0 = 1'b0; req_addr0 = '0; req_wdata0 = '0; rsp_ready0 = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstReqReady", 32'(req_ready), 32'd0);
    checkOutput("rstRspValid", 32'(rsp_valid), 32'd0);
    checkOutput("rstRspData", rsp_rdata, 32'd0);
    checkOutput("rstRspErr", 32'(rsp_err), 32'd0);
    checkOutput("rstReqReady0", 32'(req_ready0), 32'd0);
    rst_n = 1'b1;
    checkOutput("readyBeforeClk", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    checkOutput("readyAfterClk", 32'(req_ready), 32'd1);

    applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0);
    applyStimulus(1'b0, 32'h10, 32'h0, 0, 1'b0);
    applyStimulus(1'b0, 32'h13, 32'h0, 0, 1'b0);

    applyStimulus(1'b1, 32'h0, 32'h12345678, 0, 1'b0);
    applyStimulus(1'b0, 32'h400, 32'h0, 0, 1'b0);
    applyStimulus(1'b1, 32'h400, 32'h1, 0, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 0, 1'b0);

    applyStimulus(1'b0, 32'h10, 32'h0, 10, 1'b1);

    // Abort a write in WAIT with reset; the write itself must stay committed.
    model[8]  = 32'h55;
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h55;
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkOutput("waitNotReady", 32'(req_ready), 32'd0);
    rst_n = 1'b0;
    #2;
    checkOutput("abortRstValid", 32'(rsp_valid), 32'd0);
    checkOutput("abortRstReady", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      checkOutput("abortNoRsp", 32'(rsp_valid), 32'd0);
    end
    applyStimulus(1'b0, 32'h20, 32'h0, 0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      idx = int'($urandom_range(0, 15));
      if (!written[idx] || $urandom_range(0, 1) == 1) begin
        d = $urandom;
        written[idx] = 1'b1;
        applyStimulus(1'b1, {22'd0, 8'(idx), 2'($urandom_range(0, 3))}, d, int'($urandom_range(0, 2)), 1'b0);
      end else begin
        applyStimulus(1'b0, {22'd0, 8'(idx), 2'($urandom_range(0, 3))}, 32'h0, int'($urandom_range(0, 2)), 1'b0);
      end
    end

    addrs0 = '{32'h40, 32'h44, 32'h48, 32'h40, 32'h48, 32'h44};
    datas0 = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'h0, 32'h0, 32'h0};
    for (int i = 0; i < 6; i++) begin
      e.err = 1'b0;
      if (i < 3) begin
        model0[addrs0[i][9:2]] = datas0[i];
        e.data = 32'd0;
      end else begin
        e.data = model0[addrs0[i][9:2]];
      end
      req_valid0 = 1'b1;
      req_write0 = (i < 3);
      req_addr0  = addrs0[i];
      req_wdata0 = datas0[i];
      n = 0;
      while (!req_ready0 && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      if (n >= 50) checkOutput("acceptTimeout0", 32'd0, 32'd1);
      @(posedge clk); #1;
      e.acceptEdge = edgeCount;
      sb0.push_back(e);
    end
    req_valid0 = 1'b0;
    n = 0;
    while (sb0.size() != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb0.size() != 0) checkOutput("rspTimeout0", 32'd0, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rspCount0", 32'(count0), 32'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
